// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg: shared definitions for the CPU internal bus.
// Holds the bus width constants, the mux select type and the arbiter
// state encoding. The bus mux, the control unit and the arbiter all use
// these.
package cpu_bus_pkg;

  localparam int N_SRC = 16;
  localparam int SEL_W = 4;

  typedef logic [SEL_W-1:0] sel_t;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_e;

  // One-hot grant vector for a given source index.
  function automatic logic [N_SRC-1:0] onehot(sel_t idx);
    logic [N_SRC-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin search.
// Returns the first set bit of req, scanning upward from start and
// wrapping 15 -> 0. The start position itself is included.
//   req   [15:0] in  : request vector
//   start [3:0]  in  : first index to examine
//   idx   [3:0]  out : winning index (0 when nothing found)
//   found        out : at least one request bit is set
module rr_pick
  import cpu_bus_pkg::*;
(
  input  logic [N_SRC-1:0] req,
  input  sel_t             start,
  output sel_t             idx,
  output logic             found
);

  sel_t pos;

  // Scan from the far end back toward start so the closest hit is the
  // last one written and therefore wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      pos = start + SEL_W'(i);
      if (req[pos]) begin
        idx   = pos;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin owner selection for the 16-source CPU bus mux.
// Grants the bus to one requester, drives the mux select and forces a
// hand-off once an owner has held the bus for MAX_HOLD cycles (0 = no
// limit). All outputs are registered.
//   clock         in  : system clock, rising edge
//   clear         in  : synchronous active-high reset
//   req    [15:0] in  : per-source request lines
//   grant  [15:0] out : one-hot grant, zero when idle
//   sel    [3:0]  out : mux select, parked at last owner when idle
//   bus_valid     out : grant is non-zero
//   hold_expired  out : one-cycle pulse on a forced hand-off
//
// state | meaning
// IDLE  | no owner; next request found from last+1 is granted
// OWNED | sel_q is the owner; cnt_q counts its grant cycles
module bus_arbiter
  import cpu_bus_pkg::sel_t, cpu_bus_pkg::SEL_W, cpu_bus_pkg::arb_state_e,
         cpu_bus_pkg::IDLE, cpu_bus_pkg::OWNED, cpu_bus_pkg::onehot;
#(
  parameter int N_SRC    = 16,
  parameter int MAX_HOLD = 8
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [N_SRC-1:0] req,
  output logic [N_SRC-1:0] grant,
  output sel_t             sel,
  output logic             bus_valid,
  output logic             hold_expired
);

  localparam int CNT_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

  arb_state_e       state_q, state_d;
  logic [N_SRC-1:0] grant_q, grant_d;
  sel_t             sel_q, sel_d;
  sel_t             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             hexp_q, hexp_d;

  sel_t pick_start;
  sel_t pick_idx;
  logic pick_found;

  // While owned the search begins after the owner; while idle it begins
  // after the most recent winner. sel_q is the owner when OWNED.
  assign pick_start = (state_q == OWNED) ? sel_q + 1'b1 : last_q + 1'b1;

  rr_pick u_pick (
    .req   (req),
    .start (pick_start),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    hexp_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = OWNED;
          grant_d = onehot(pick_idx);
          sel_d   = pick_idx;
          last_d  = pick_idx;
          cnt_d   = '0;
          valid_d = 1'b1;
        end
      end
      OWNED: begin
        if (!req[sel_q]) begin
          // Release wins over expiry, so no pulse here.
          if (pick_found) begin
            grant_d = onehot(pick_idx);
            sel_d   = pick_idx;
            last_d  = pick_idx;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            valid_d = 1'b0;
          end
        end else if ((MAX_HOLD != 0) && (cnt_q == CNT_LAST)) begin
          // req[sel_q] is set, so the search always finds someone,
          // possibly the same owner again.
          grant_d = onehot(pick_idx);
          sel_d   = pick_idx;
          last_d  = pick_idx;
          cnt_d   = '0;
          hexp_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      last_q  <= SEL_W'(15);
      cnt_q   <= '0;
      valid_q <= 1'b0;
      hexp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      hexp_q  <= hexp_d;
    end
  end

  assign grant        = grant_q;
  assign sel          = sel_q;
  assign bus_valid    = valid_q;
  assign hold_expired = hexp_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed bench for bus_arbiter.
// Four instances share the clock and clear: index 0 uses MAX_HOLD=8,
// 1 uses 2, 2 uses 4, 3 uses 0 (unlimited).
module tb_bus_arbiter;

  logic        clock;
  logic        clear;
  logic [15:0] req_a   [4];
  logic [15:0] grant_a [4];
  logic [3:0]  sel_a   [4];
  logic        valid_a [4];
  logic        hexp_a  [4];

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int          dut;
    logic [15:0] req;
    logic [15:0] g;
    logic [3:0]  s;
    logic        v;
    logic        h;
  } vec_t;

  vec_t vecs[17];

  bus_arbiter #(.N_SRC(16), .MAX_HOLD(8)) u_m8 (
    .clock(clock), .clear(clear), .req(req_a[0]), .grant(grant_a[0]),
    .sel(sel_a[0]), .bus_valid(valid_a[0]), .hold_expired(hexp_a[0]));
  bus_arbiter #(.N_SRC(16), .MAX_HOLD(2)) u_m2 (
    .clock(clock), .clear(clear), .req(req_a[1]), .grant(grant_a[1]),
    .sel(sel_a[1]), .bus_valid(valid_a[1]), .hold_expired(hexp_a[1]));
  bus_arbiter #(.N_SRC(16), .MAX_HOLD(4)) u_m4 (
    .clock(clock), .clear(clear), .req(req_a[2]), .grant(grant_a[2]),
    .sel(sel_a[2]), .bus_valid(valid_a[2]), .hold_expired(hexp_a[2]));
  bus_arbiter #(.N_SRC(16), .MAX_HOLD(0)) u_m0 (
    .clock(clock), .clear(clear), .req(req_a[3]), .grant(grant_a[3]),
    .sel(sel_a[3]), .bus_valid(valid_a[3]), .hold_expired(hexp_a[3]));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string nm, input int d, input logic [15:0] g,
                       input logic [3:0] s, input logic v, input logic h);
    n_checks++;
    if (grant_a[d] !== g || sel_a[d] !== s || valid_a[d] !== v || hexp_a[d] !== h) begin
      n_errors++;
      $display("FAIL %s (dut %0d): got grant=%h sel=%0d valid=%b hexp=%b, want grant=%h sel=%0d valid=%b hexp=%b",
               nm, d, grant_a[d], sel_a[d], valid_a[d], hexp_a[d], g, s, v, h);
    end
  endtask

  initial begin
    // Round robin on MAX_HOLD=2: 0,5,10,15,0 with two cycles each.
    vecs[0]  = '{1, 16'h8421, 16'h0001, 4'd0,  1'b1, 1'b0};
    vecs[1]  = '{1, 16'h8421, 16'h0001, 4'd0,  1'b1, 1'b0};
    vecs[2]  = '{1, 16'h8421, 16'h0020, 4'd5,  1'b1, 1'b1};
    vecs[3]  = '{1, 16'h8421, 16'h0020, 4'd5,  1'b1, 1'b0};
    vecs[4]  = '{1, 16'h8421, 16'h0400, 4'd10, 1'b1, 1'b1};
    vecs[5]  = '{1, 16'h8421, 16'h0400, 4'd10, 1'b1, 1'b0};
    vecs[6]  = '{1, 16'h8421, 16'h8000, 4'd15, 1'b1, 1'b1};
    vecs[7]  = '{1, 16'h8421, 16'h8000, 4'd15, 1'b1, 1'b0};
    vecs[8]  = '{1, 16'h8421, 16'h0001, 4'd0,  1'b1, 1'b1};
    vecs[9]  = '{1, 16'h8421, 16'h0001, 4'd0,  1'b1, 1'b0};
    // Release and wrap on MAX_HOLD=8 (idle, last=0, sel parked at 0).
    vecs[10] = '{0, 16'h0000, 16'h0000, 4'd0,  1'b0, 1'b0};
    vecs[11] = '{0, 16'h0008, 16'h0008, 4'd3,  1'b1, 1'b0};
    vecs[12] = '{0, 16'h0008, 16'h0008, 4'd3,  1'b1, 1'b0};
    vecs[13] = '{0, 16'h0008, 16'h0008, 4'd3,  1'b1, 1'b0};
    vecs[14] = '{0, 16'h0000, 16'h0000, 4'd3,  1'b0, 1'b0};
    vecs[15] = '{0, 16'h0009, 16'h0001, 4'd0,  1'b1, 1'b0};
    vecs[16] = '{0, 16'h0000, 16'h0000, 4'd0,  1'b0, 1'b0};

    // Reset default: clear held two cycles with every source requesting.
    clear = 1'b1;
    for (int d = 0; d < 4; d++) req_a[d] = 16'hFFFF;
    for (int c = 0; c < 2; c++) begin
      step();
      check("reset_m8", 0, 16'h0000, 4'd0, 1'b0, 1'b0);
      check("reset_m2", 1, 16'h0000, 4'd0, 1'b0, 1'b0);
    end
    clear = 1'b0;
    for (int d = 1; d < 4; d++) req_a[d] = 16'h0000;
    step();
    check("first_grant", 0, 16'h0001, 4'd0, 1'b1, 1'b0);
    req_a[0] = 16'h0000;

    for (int i = 0; i < 17; i++) begin
      req_a[vecs[i].dut] = vecs[i].req;
      step();
      check($sformatf("vec%0d", i), vecs[i].dut, vecs[i].g, vecs[i].s,
            vecs[i].v, vecs[i].h);
    end

    // Sole requester on MAX_HOLD=4: re-grant every 4 cycles with a pulse,
    // then a release that coincides with expiry gives no pulse.
    req_a[2] = 16'h0080;
    for (int k = 1; k <= 16; k++) begin
      step();
      check($sformatf("sole_k%0d", k), 2, 16'h0080, 4'd7, 1'b1,
            (k > 1) && ((k - 1) % 4 == 0));
    end
    req_a[2] = 16'h0000;
    step();
    check("sole_release_race", 2, 16'h0000, 4'd7, 1'b0, 1'b0);

    // Unlimited hold: source 0 keeps the bus for 50 cycles, then hands
    // off to source 1 with no idle cycle.
    req_a[3] = 16'h0003;
    for (int k = 1; k <= 50; k++) begin
      step();
      check($sformatf("unlim_k%0d", k), 3, 16'h0001, 4'd0, 1'b1, 1'b0);
    end
    req_a[3] = 16'h0002;
    step();
    check("unlim_handoff", 3, 16'h0002, 4'd1, 1'b1, 1'b0);

    // Reset mid-grant on MAX_HOLD=2: source 9 owns, clear lands on the
    // edge where its hold would expire.
    req_a[1] = 16'h0200;
    step();
    check("mid_own9", 1, 16'h0200, 4'd9, 1'b1, 1'b0);
    step();
    check("mid_own9_c1", 1, 16'h0200, 4'd9, 1'b1, 1'b0);
    clear    = 1'b1;
    req_a[1] = 16'h0201;
    step();
    check("mid_clear", 1, 16'h0000, 4'd0, 1'b0, 1'b0);
    clear = 1'b0;
    step();
    check("mid_after", 1, 16'h0001, 4'd0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
